// File: rtl/uart_tx_gen2.sv
// uart_tx_gen2 -- queued UART transmitter with programmable divisor, parity and stop bits.
// Build option: define UART_TX_FIFO_EN for a FIFO_DEPTH-entry transmit queue;
// otherwise a single holding register buffers one pending word.
//
// state  | meaning
// IDLE   | line high, waiting for a queued word
// START  | start bit (Tx=0)
// DATA   | shifting data bits out LSB first
// PARITY | parity bit (skipped when parity is off)
// STOP   | one or two stop bits (Tx=1)
`timescale 1ns/1ps
module uart_tx_gen2 #(
  parameter int DATA_W     = 9,
  parameter int DIV_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [DATA_W-1:0] Data,
  input  logic [DIV_W-1:0]  Divisor,
  input  logic [1:0]        ParityMode,
  input  logic              StopBits,
  output logic              Tx,
  output logic              Busy,
  output logic              Full,
  output logic              Overrun
);

  localparam int BIT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state_q, state_d;
  logic              start_q, start_d;
  logic              start_prev_q, start_prev_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              par_en_q, par_en_d;
  logic              par_q, par_d;
  logic              stop2_q, stop2_d;
  logic              stop_left_q, stop_left_d;
  logic              overrun_q, overrun_d;

  logic              write;
  logic              push;
  logic              pop;
  logic              q_empty;
  logic              q_full;
  logic [DATA_W-1:0] head;
  logic [DIV_W-1:0]  div_eff;
  logic              tick;
  logic              begin_frame;

  // A write is the rising edge of the registered Start; a pop in the same
  // cycle frees a slot so a write against a full queue is still taken.
  assign write     = start_q & ~start_prev_q;
  assign push      = write & (~q_full | pop);
  assign overrun_d = write & ~push;
  assign start_d      = Start;
  assign start_prev_d = start_q;

  assign div_eff = (Divisor == '0) ? DIV_W'(1) : Divisor;
  assign tick    = (cnt_q == '0);

`ifdef UART_TX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;

  assign q_empty = (count_q == '0);
  assign q_full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign head    = mem_q[rd_ptr_q];

  // Queue bookkeeping: pointers wrap naturally at the power-of-two depth.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = Data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + (PTR_W+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (PTR_W+1)'(1);
    end
  end

  // Queue storage; contents are don't-care while the count says empty.
  always_ff @(posedge Clock) begin
    mem_q <= mem_d;
  end

  // Queue pointers and occupancy.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
`else
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;

  assign q_empty = ~hold_vld_q;
  assign q_full  = hold_vld_q;
  assign head    = hold_q;

  // Single holding register; a push in the pop cycle refills it.
  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    if (pop) begin
      hold_vld_d = 1'b0;
    end
    if (push) begin
      hold_d     = Data;
      hold_vld_d = 1'b1;
    end
  end

  // Holding register state.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
    end
  end
`endif

  // Frame sequencing: each bit lasts div_q cycles of the down-counter; the
  // frame configuration is captured when the word is popped into the shifter.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    div_d       = div_q;
    par_en_d    = par_en_q;
    par_d       = par_q;
    stop2_d     = stop2_q;
    stop_left_d = stop_left_q;
    pop         = 1'b0;
    begin_frame = 1'b0;

    if (state_q != IDLE && !tick) begin
      cnt_d = cnt_q - DIV_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (!q_empty) begin
          begin_frame = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = BIT_W'(DATA_W - 1);
          cnt_d   = div_q - DIV_W'(1);
        end
      end
      DATA: begin
        if (tick) begin
          cnt_d = div_q - DIV_W'(1);
          if (bit_q != '0) begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            bit_d   = bit_q - BIT_W'(1);
          end else if (par_en_q) begin
            state_d = PARITY;
            tx_d    = par_q;
          end else begin
            state_d     = STOP;
            tx_d        = 1'b1;
            stop_left_d = stop2_q;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d     = STOP;
          tx_d        = 1'b1;
          stop_left_d = stop2_q;
          cnt_d       = div_q - DIV_W'(1);
        end
      end
      STOP: begin
        if (tick) begin
          if (stop_left_q) begin
            stop_left_d = 1'b0;
            cnt_d       = div_q - DIV_W'(1);
          end else if (!q_empty) begin
            begin_frame = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (begin_frame) begin
      pop      = 1'b1;
      state_d  = START;
      tx_d     = 1'b0;
      shift_d  = head;
      div_d    = div_eff;
      cnt_d    = div_eff - DIV_W'(1);
      par_en_d = (ParityMode == 2'b01) || (ParityMode == 2'b10);
      par_d    = (^head) ^ (ParityMode == 2'b10);
      stop2_d  = StopBits;
    end
  end

  // Transmitter state; reset aborts any frame and returns the line to idle.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      start_prev_q <= 1'b0;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      tx_q         <= 1'b1;
      div_q        <= DIV_W'(1);
      par_en_q     <= 1'b0;
      par_q        <= 1'b0;
      stop2_q      <= 1'b0;
      stop_left_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      start_prev_q <= start_prev_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
      div_q        <= div_d;
      par_en_q     <= par_en_d;
      par_q        <= par_d;
      stop2_q      <= stop2_d;
      stop_left_q  <= stop_left_d;
      overrun_q    <= overrun_d;
    end
  end

  assign Tx      = tx_q;
  assign Busy    = (state_q != IDLE) | ~q_empty;
  assign Full    = q_full;
  assign Overrun = overrun_q;

endmodule

// File: tb/tb_uart_tx_gen2.sv
// Testbench for uart_tx_gen2: expected frames are built from the line-format
// rules and queued at write time; a monitor pops them as frames appear on Tx.
`timescale 1ns/1ps
module tb_uart_tx_gen2;

  localparam int DATA_W     = 9;
  localparam int DIV_W      = 8;
  localparam int FIFO_DEPTH = 4;
`ifdef UART_TX_FIFO_EN
  localparam int CAP = FIFO_DEPTH;
`else
  localparam int CAP = 1;
`endif
  localparam int BURST_MAX = (CAP + 1 > 3) ? 3 : CAP + 1;

  logic              Clock;
  logic              Reset;
  logic              Start;
  logic [DATA_W-1:0] Data;
  logic [DIV_W-1:0]  Divisor;
  logic [1:0]        ParityMode;
  logic              StopBits;
  logic              Tx;
  logic              Busy;
  logic              Full;
  logic              Overrun;

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    int          div;
    bit          b2b;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   ovr_cnt = 0;
  int   frames_seen = 0;
  bit   in_frame = 0;
  bit   abort = 0;
  int   wr_cyc = 0;

  uart_tx_gen2 #(.DATA_W(DATA_W), .DIV_W(DIV_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Data(Data), .Divisor(Divisor),
    .ParityMode(ParityMode), .StopBits(StopBits), .Tx(Tx), .Busy(Busy),
    .Full(Full), .Overrun(Overrun)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  always @(posedge Clock) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  // Line image of one frame: start, data LSB first, optional parity, stops.
  function automatic exp_t model(input logic [DATA_W-1:0] d, input int div,
                                 input logic [1:0] pm, input logic two_stop, input bit b2b);
    exp_t e;
    int   n;
    int   ones;
    e.bits = '1;
    e.bits[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < DATA_W; i++) begin
      e.bits[1+i] = d[i];
      ones += int'(d[i]);
    end
    n = 1 + DATA_W;
    if (pm == 2'b01 || pm == 2'b10) begin
      e.bits[n] = ((ones % 2) == 1) ^ (pm == 2'b10);
      n++;
    end
    n += two_stop ? 2 : 1;
    e.nbits = n;
    e.div   = (div == 0) ? 1 : div;
    e.b2b   = b2b;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic cfg(input int div, input logic [1:0] pm, input logic two_stop);
    @(negedge Clock);
    Divisor    = DIV_W'(div);
    ParityMode = pm;
    StopBits   = two_stop;
  endtask

  task automatic do_write(input logic [DATA_W-1:0] d, input int hold);
    @(negedge Clock);
    Data  = d;
    Start = 1'b1;
    @(negedge Clock);
    wr_cyc = cyc;
    repeat (hold - 1) @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input int hold, input bit b2b);
    sb.push_back(model(d, int'(Divisor), ParityMode, StopBits, b2b));
    do_write(d, hold);
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while (k < limit && (sb.size() != 0 || in_frame || Busy !== 1'b0)) begin
      @(negedge Clock);
      k++;
    end
    if (k >= limit) begin
      n_checks++;
      $display("FAIL idle_timeout: still busy after %0d cycles, want idle", limit);
    end
    repeat (2) @(negedge Clock);
  endtask

  // Overrun pulse counter.
  initial begin
    forever begin
      @(posedge Clock); #1;
      if (Overrun === 1'b1) ovr_cnt++;
    end
  end

  // Monitor: match each frame on Tx against the head of the scoreboard.
  initial begin : monitor
    exp_t cur;
    int   idx;
    bit   bad;
    int   bad_idx;
    logic bad_act;
    logic want;
    bit   just_ended;
    idx = 0; bad = 0; bad_idx = 0; bad_act = 1'b0; just_ended = 0;
    cur = model('0, 1, 2'b00, 1'b0, 1'b0);
    forever begin
      @(posedge Clock); #1;
      if (abort) begin
        in_frame = 0;
        just_ended = 0;
        continue;
      end
      if (!in_frame) begin
        if (Tx === 1'b0) begin
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_frame: Tx=0 at cycle %0d, want 1 (nothing queued)", cyc);
          end else begin
            cur = sb.pop_front();
            if (cur.b2b) check("b2b_gap", {31'b0, just_ended}, 32'd1);
            in_frame = 1; idx = 0; bad = 0;
          end
        end else if (just_ended && sb.size() == 0) begin
          check("idle_after_frame", {31'b0, Busy}, 32'd0);
        end
        just_ended = 0;
      end
      if (in_frame) begin
        want = cur.bits[idx / cur.div];
        if (Tx !== want && !bad) begin
          bad = 1; bad_idx = idx; bad_act = Tx;
        end
        idx++;
        if (idx == cur.nbits * cur.div) begin
          n_checks++;
          if (!bad) n_pass++;
          else $display("FAIL frame %0d: cycle %0d Tx=%b, want %b", frames_seen, bad_idx,
                        bad_act, cur.bits[bad_idx / cur.div]);
          in_frame = 0; just_ended = 1; frames_seen++;
        end
      end
    end
  end

  initial begin
    int   o0;
    int   f0;
    int   fs;
    int   len;
    int   div;
    int   k;
    exp_t e;
    logic [DATA_W-1:0] d;

    Reset = 1'b0; Start = 1'b0; Data = '0; Divisor = DIV_W'(1);
    ParityMode = 2'b00; StopBits = 1'b0;
    repeat (3) @(posedge Clock); #1;
    check("rst_tx", {31'b0, Tx}, 32'd1);
    check("rst_busy", {31'b0, Busy}, 32'd0);
    check("rst_full", {31'b0, Full}, 32'd0);
    check("rst_overrun", {31'b0, Overrun}, 32'd0);
    @(negedge Clock);
    Reset = 1'b1;

    // Even parity, divisor 2, with start latency from an idle line.
    cfg(2, 2'b01, 1'b0);
    send(9'b100101110, 1, 0);
    @(posedge Clock); #1;
    check("latency_edge1", {31'b0, Tx}, 32'd1);
    @(posedge Clock); #1;
    check("latency_edge2", {31'b0, Tx}, 32'd0);
    wait_idle(500);

    // Odd parity, divisor 3; configuration changes mid-frame are ignored.
    cfg(3, 2'b10, 1'b0);
    send(9'b101010110, 1, 0);
    repeat (8) @(negedge Clock);
    Divisor = DIV_W'(7); ParityMode = 2'b00; StopBits = 1'b1;
    wait_idle(500);

    // No parity, two stop bits, divisor 0 treated as 1.
    cfg(0, 2'b11, 1'b1);
    send(DATA_W'($urandom), 1, 0);
    wait_idle(500);

    // Start held high produces one frame only.
    cfg($urandom_range(1, 3), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    f0 = frames_seen;
    send(DATA_W'($urandom), 10, 0);
    wait_idle(1000);
    check("hold_one_frame", frames_seen - f0, 32'd1);

    // Overflow during one long frame.
    cfg($urandom_range(6, 10), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    o0 = ovr_cnt;
    send(DATA_W'($urandom), 1, 0);
    for (int i = 1; i <= FIFO_DEPTH + 1; i++) begin
      if (i <= CAP) send(DATA_W'($urandom), 1, 1);
      else do_write(DATA_W'($urandom), 1);
    end
    @(negedge Clock);
    check("full_after_burst", {31'b0, Full}, 32'd1);
    repeat (2) @(negedge Clock);
    check("overrun_count", ovr_cnt - o0, FIFO_DEPTH + 1 - CAP);
    wait_idle(8000);

    // Write against a full queue in the cycle the head is popped.
    cfg($urandom_range(4, 6), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    o0 = ovr_cnt;
    d = DATA_W'($urandom);
    e = model(d, int'(Divisor), ParityMode, StopBits, 1'b0);
    len = e.nbits * e.div;
    send(d, 1, 0);
    fs = wr_cyc + 2;
    for (int i = 1; i <= CAP; i++) send(DATA_W'($urandom), 1, 1);
    while (cyc < fs + len - 3) @(negedge Clock);
    @(negedge Clock);
    check("full_before_simul", {31'b0, Full}, 32'd1);
    d = DATA_W'($urandom);
    sb.push_back(model(d, int'(Divisor), ParityMode, StopBits, 1'b1));
    Data = d; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (3) @(negedge Clock);
    check("simul_no_overrun", ovr_cnt - o0, 32'd0);
    wait_idle(8000);

    // Reset in the middle of the data bits, then a clean frame.
    cfg($urandom_range(2, 4), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    div = int'(Divisor);
    send(DATA_W'($urandom), 1, 0);
    fs = wr_cyc + 2;
    while (cyc < fs + 3 * div) @(negedge Clock);
    check("busy_mid_frame", {31'b0, Busy}, 32'd1);
    abort = 1; Reset = 1'b0;
    @(posedge Clock); #1;
    check("abort_tx", {31'b0, Tx}, 32'd1);
    check("abort_busy", {31'b0, Busy}, 32'd0);
    check("abort_full", {31'b0, Full}, 32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    abort = 0;
    send(DATA_W'($urandom), 1, 0);
    wait_idle(1000);

    // Random configurations and short bursts.
    for (int it = 0; it < 8; it++) begin
      cfg($urandom_range(0, 4), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      k = $urandom_range(1, BURST_MAX);
      send(DATA_W'($urandom), 1, 0);
      for (int j = 1; j < k; j++) send(DATA_W'($urandom), 1, 1);
      wait_idle(3000);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_gen2.md
UART_TX_GEN2 -- requirements
Module: uart_tx_gen2

Interface
REQ-001 SHALL have parameter DATA_W, default 9: data bits per frame, legal 5..9.
REQ-002 SHALL have parameter DIV_W, default 8: width of the baud divisor.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: transmit queue entries, power of 2, at least 2.
REQ-004 SHALL have port Clock, input, 1 bit: the single clock; all logic acts on its rising edge.
REQ-005 SHALL have port Reset, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port Start, input, 1 bit: write request; a write is a 0->1 transition sampled on Clock.
REQ-007 SHALL have port Data, input, DATA_W bits: the word captured on a write.
REQ-008 SHALL have port Divisor, input, DIV_W bits: bit period in Clock cycles; 0 is treated as 1.
REQ-009 SHALL have port ParityMode, input, 2 bits: 00 none, 01 even, 10 odd, 11 none.
REQ-010 SHALL have port StopBits, input, 1 bit: 0 gives one stop bit, 1 gives two.
REQ-011 SHALL have port Tx, output, 1 bit: serial line, idle high.
REQ-012 SHALL have port Busy, output, 1 bit: frame in progress or queue non-empty.
REQ-013 SHALL have port Full, output, 1 bit: queue cannot accept a write.
REQ-014 SHALL have port Overrun, output, 1 bit: one-cycle pulse when a write is dropped.

Function
REQ-015 SHALL register Start and detect writes on its rising edge only; holding Start high SHALL produce exactly one write.
REQ-016 SHALL push Data into the queue on a write when Full=0; a write while Full=1 SHALL be dropped and Overrun pulsed on the next cycle.
REQ-017 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
- IDLE->START when the queue is non-empty.
- START->DATA after one bit period.
- DATA->PARITY or STOP after DATA_W bits.
- PARITY->STOP after one bit period.
- STOP->START if the queue is non-empty, otherwise ->IDLE.
REQ-018 SHALL latch Divisor, ParityMode and StopBits on entry to START; changes mid-frame SHALL NOT affect the current frame.
REQ-019 SHALL pop the queue head on entry to START into a shift register and send it LSB first.
REQ-020 SHALL hold each bit for max(Divisor,1) cycles using a DIV_W-bit down-counter.
REQ-021 SHALL drive Tx from a register: 0 in START, the data bit in DATA, the parity bit in PARITY, and 1 in STOP and IDLE.
REQ-022 SHALL make the even-parity bit the XOR of the data bits and the odd-parity bit its inverse; with no parity the PARITY state SHALL be skipped.
REQ-023 SHALL take exactly (1+DATA_W+P+S)*max(Divisor,1) cycles per frame, where P is 0/1 for parity and S is 1/2 stop bits.
REQ-024 SHALL, when idle and the queue is empty, drive Tx low on the second rising edge after Start is sampled high.
REQ-025 SHALL start back-to-back frames with no idle gap between the last stop bit and the next start bit.
REQ-026 SHALL accept a simultaneous push and pop when Full=1: the pop frees the slot, the write is accepted and no Overrun is raised.
REQ-027 SHALL wrap queue pointers modulo FIFO_DEPTH and keep a count of log2(FIFO_DEPTH)+1 bits.

Reset
REQ-028 SHALL, while Reset=0 at a Clock edge, set the FSM to IDLE, empty the queue, clear the counters and the Start history, and drive Tx=1, Busy=0, Full=0, Overrun=0.
REQ-029 SHALL abort a frame in progress when reset mid-frame, with Tx=1 on the next cycle and no partial-frame resumption.

Configuration
REQ-030 SHALL, when UART_TX_FIFO_EN is defined, implement the FIFO_DEPTH-entry queue described above.
REQ-031 SHALL, when UART_TX_FIFO_EN is undefined, replace the queue with a single holding register (Full = register occupied), ignore FIFO_DEPTH, and keep all other behaviour identical.

Verification
REQ-032 SHALL verify: DATA_W=9, Divisor=2, even parity, one stop bit, Data=9'b100101110 -> Tx bits 0,0,1,1,1,0,1,0,0,1,1(parity),1, each 2 cycles, 24 cycles total.
REQ-033 SHALL verify: odd parity, Divisor=3, Data=9'b101010110 -> parity bit 0, frame length 36 cycles; changing Divisor mid-frame leaves the length unchanged.
REQ-034 SHALL verify: no parity, StopBits=1, Divisor=0 -> parity state skipped, two stop bits, 1 cycle per bit, 12 cycles total.
REQ-035 SHALL verify: FIFO_DEPTH+2 writes during one frame -> Full asserts, one Overrun pulse per dropped write, queued frames sent back-to-back with no idle gap.
REQ-036 SHALL verify: Start held high for 10 cycles -> exactly one frame sent.
REQ-037 SHALL verify: Reset=0 in the middle of the DATA state -> Tx=1, Busy=0 and Full=0 on the next cycle, and the next write sends a complete, correct frame.
